uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Transmit scheduler that owns the uart register bus and shares its transmitter between N on-chip byte producers.
- After reset it configures the uart (CPB, CTRL), then round-robin arbitrates requesters.
- Before each write to DR it polls TSTAT.TC and waits until the transmitter is free.
- Sits between producer blocks (console, debug monitor, log streams) and the uart's cs/wen/addr/din/dout port.

Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 32, uart register data width
- CPB_INIT, 217, value written to uart CPB (address 4) at init
- CTRL_INIT, 3, value written to uart CTRL (address 1) at init; bit0 RX_EN, bit1 TX_EN
- SETTLE, 2, idle cycles after a DR write before the next TSTAT poll (1..15)
- TIMEOUT, 65535, poll cycles before the watchdog fires (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N  per-requester byte-pending request; held high until ack
- req_data  in  8*N  byte of requester i on bits [8i+7:8i]; held stable while req[i]=1
- ack  out  N  one-cycle pulse: byte of requester i written to uart DR this cycle
- busy  out  1  high in any state other than IDLE
- m_cs  out  1  uart chip select
- m_wen  out  1  uart write enable
- m_addr  out  4  uart register address
- m_din  out  WIDTH  uart write data
- m_dout  in  WIDTH  uart read data (combinational from m_addr)
- wd_err  out  1  sticky watchdog error (optional feature; tied 0 without it)

Behaviour:
- All bus outputs (m_cs, m_wen, m_addr, m_din) are registered-state decoded. When m_cs=0, m_wen=0, m_addr=0 and m_din=0.
- Reset values: ack=0, m_cs=0, wd_err=0, round-robin pointer ptr=0, state=INIT_CPB. busy=1 during reset-exit init.
- States:
  - INIT_CPB: m_cs=1, m_wen=1, m_addr=4, m_din=CPB_INIT. Next state INIT_CTRL.
  - INIT_CTRL: m_cs=1, m_wen=1, m_addr=1, m_din=CTRL_INIT. Next state IDLE.
  - IDLE: bus inactive. Goes to POLL if |req, else stays.
  - POLL: m_cs=1, m_wen=0, m_addr=3. m_dout[0] (TC) is sampled at the clock edge. TC=1 goes to WRITE; TC=0 stays in POLL, reading every cycle.
  - WRITE: winner w is computed combinationally this cycle from the current req and ptr. Priority order is ptr, ptr+1, ... mod N.
    - If req==0: no bus access, no ack, next state IDLE.
    - Otherwise: m_cs=1, m_wen=1, m_addr=0, m_din={0, req_data[w]}, ack[w]=1, ptr<=(w+1) mod N, next state SETTLE.
  - SETTLE: bus idle for exactly SETTLE cycles (down-counter), then IDLE. This covers the delay between the DR write and tx_busy rising in the uart.
- Throughput: the first byte reaches DR 3 cycles after req rises, if TC=1 (IDLE, POLL, WRITE).
- At most one ack bit is set per cycle. Exactly one ack is issued per written byte.
- A requester holding req continuously gets at most one byte per N grants while others are pending (fairness).
- A requester dropping req before ack is legal. Its byte is simply not sent.
- Reset mid-operation returns to INIT_CPB on the next edge. Any transfer the uart has in flight is the uart's concern. No ack is issued for the aborted cycle.

Optional Feature:
- Macro: UART_SCHED_WATCHDOG_EN.
- With the macro:
  - A 16-bit counter clears on POLL entry and increments each POLL cycle.
  - On reaching TIMEOUT: wd_err<=1 (sticky until reset), next state INIT_CPB, which re-initialises the uart.
  - No ack is issued for the pending requester, which retries after re-init.
- Without the macro: no counter; POLL waits indefinitely; wd_err is constant 0.

Decomposition:
- Shared package uart_pkg:
  - uart register addresses: DR=0, CTRL=1, RSTAT=2, TSTAT=3, CPB=4, QUEUE=5
  - bit indices: TC=0, RX_EN=0, TX_EN=1
  - scheduler state encoding (3-bit enum)
- One sub-module, rr_arbiter:
  - Parameter N; inputs req and ptr; outputs one-hot grant and grant index. Purely combinational.
  - Pointer update stays in uart_tx_sched.

Test Plan:
- Reset release: bus shows write addr 4 data 217, then write addr 1 data 3, then m_cs=0 and busy=0.
- Single request, TC=1: req=4'b0010, req_data[15:8]=8'h41. Expect TSTAT read next cycle, then DR write with m_din=32'h41 and ack=4'b0010, then SETTLE=2 idle cycles.
- TC held 0 for 10 cycles: 10 consecutive TSTAT reads and no DR write. On the first cycle with TC=1, WRITE follows on the next edge.
- All four requesting continuously with bytes 8'h10..8'h13: ack order 0,1,2,3,0. DR data matches per requester.
- Requester 2 drops req during POLL (only requester): WRITE sees req=0, no bus write, no ack, return to IDLE.
- With UART_SCHED_WATCHDOG_EN and TIMEOUT=8: TC stuck 0 gives wd_err=1 after 8 POLL cycles, then re-init writes (addr 4, addr 1), then a fresh POLL.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared uart register map, bit positions and scheduler state encoding.
package uart_pkg;

    localparam logic [3:0] ADDR_DR    = 4'd0;
    localparam logic [3:0] ADDR_CTRL  = 4'd1;
    localparam logic [3:0] ADDR_RSTAT = 4'd2;
    localparam logic [3:0] ADDR_TSTAT = 4'd3;
    localparam logic [3:0] ADDR_CPB   = 4'd4;
    localparam logic [3:0] ADDR_QUEUE = 4'd5;

    localparam int TC_BIT    = 0;
    localparam int RX_EN_BIT = 0;
    localparam int TX_EN_BIT = 1;

    typedef enum logic [2:0] {
        S_INIT_CPB,
        S_INIT_CTRL,
        S_IDLE,
        S_POLL,
        S_WRITE,
        S_SETTLE
    } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int PW = $clog2(N);

    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart transmitter between N byte producers via round-robin.
// Optional TSTAT poll watchdog: define UART_SCHED_WATCHDOG_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int CPB_INIT  = 217,
    parameter int CTRL_INIT = 3,
    parameter int SETTLE    = 2,
    parameter int TIMEOUT   = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     ack,
    output logic             busy,
    output logic             m_cs,
    output logic             m_wen,
    output logic [3:0]       m_addr,
    output logic [WIDTH-1:0] m_din,
    input  logic [WIDTH-1:0] m_dout,
    output logic             wd_err
);

    localparam int PW = $clog2(N);

    sched_state_t     state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [3:0]       cnt, cnt_n;
    logic [N-1:0]     grant;
    logic [PW-1:0]    widx;
    logic [7:0]       wbyte;
    logic             tc;
    logic             cs, wen;
    logic [3:0]       addr;
    logic [WIDTH-1:0] din;
    logic [N-1:0]     ack_c;
    logic             unused_dout;

    assign tc          = m_dout[TC_BIT];
    assign unused_dout = ^m_dout[WIDTH-1:1];
    assign wbyte       = req_data[widx*8 +: 8];

    rr_arbiter #(.N(N)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (widx)
    );

`ifdef UART_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt, wd_cnt_n;
    logic        wd_q, wd_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            wd_q   <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_n;
            if (wd_set) wd_q <= 1'b1;
        end
    end

    assign wd_err = wd_q;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign wd_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT_CPB;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        cs      = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        din     = '0;
        ack_c   = '0;
`ifdef UART_SCHED_WATCHDOG_EN
        wd_cnt_n = wd_cnt;
        wd_set   = 1'b0;
`endif
        unique case (state)
            S_INIT_CPB: begin
                cs      = 1'b1;
                wen     = 1'b1;
                addr    = ADDR_CPB;
                din     = WIDTH'(CPB_INIT);
                state_n = S_INIT_CTRL;
            end
            S_INIT_CTRL: begin
                cs      = 1'b1;
                wen     = 1'b1;
                addr    = ADDR_CTRL;
                din     = WIDTH'(CTRL_INIT);
                state_n = S_IDLE;
            end
            S_IDLE: begin
                if (|req) state_n = S_POLL;
`ifdef UART_SCHED_WATCHDOG_EN
                wd_cnt_n = '0;
`endif
            end
            S_POLL: begin
                cs   = 1'b1;
                addr = ADDR_TSTAT;
                if (tc) begin
                    state_n = S_WRITE;
                end
`ifdef UART_SCHED_WATCHDOG_EN
                else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                    wd_set  = 1'b1;
                    state_n = S_INIT_CPB;
                end else begin
                    wd_cnt_n = wd_cnt + 16'd1;
                end
`endif
            end
            S_WRITE: begin
                if (|req) begin
                    cs      = 1'b1;
                    wen     = 1'b1;
                    addr    = ADDR_DR;
                    din     = {{(WIDTH-8){1'b0}}, wbyte};
                    ack_c   = grant;
                    ptr_n   = (widx == PW'(N-1)) ? '0 : widx + 1'b1;
                    cnt_n   = 4'(SETTLE - 1);
                    state_n = S_SETTLE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) state_n = S_IDLE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = S_INIT_CPB;
        endcase
    end

    // An edge that takes reset must not see a bus write or ack this cycle.
    assign busy   = (state != S_IDLE);
    assign m_cs   = cs & ~reset;
    assign m_wen  = wen & ~reset;
    assign m_addr = reset ? 4'd0 : addr;
    assign m_din  = reset ? '0 : din;
    assign ack    = reset ? '0 : ack_c;

endmodule
